// File: rtl/uart_cmd_pkg.sv
// ============================================================================
// uart_cmd_pkg : opcodes, FSM encodings and operand addresses shared by the
//                UART command controller and its TX byte scheduler.
// Revision     : 1.0
// ============================================================================
`default_nettype none

package uart_cmd_pkg;

  localparam logic [7:0] OPC_RF_WR   = 8'hAA;
  localparam logic [7:0] OPC_RF_RD   = 8'hBB;
  localparam logic [7:0] OPC_ALU_OP  = 8'hCC;
  localparam logic [7:0] OPC_ALU_NOP = 8'hDD;

  localparam int OPA_ADDR = 0;
  localparam int OPB_ADDR = 1;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_WR_ADDR  = 4'd1,
    ST_WR_DATA  = 4'd2,
    ST_RD_ADDR  = 4'd3,
    ST_RD_WAIT  = 4'd4,
    ST_OPA      = 4'd5,
    ST_OPB      = 4'd6,
    ST_FUN      = 4'd7,
    ST_ALU_WAIT = 4'd8,
    ST_TX       = 4'd9
  } cmd_state_t;

  typedef enum logic [1:0] {
    TX_IDLE = 2'd0,
    TX_LO   = 2'd1,
    TX_HI   = 2'd2
  } tx_state_t;

endpackage

`default_nettype wire

// File: rtl/uart_cmd_tx_sched.sv
// ============================================================================
// uart_cmd_tx_sched : pushes a one- or two-byte result (LSB first) into the
//                     TX FIFO, stalling while the FIFO is full.
// Revision          : 1.0
// ============================================================================
`default_nettype none

module uart_cmd_tx_sched
  import uart_cmd_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    start,
  input  logic [2*DATA_WIDTH-1:0] result,
  input  logic                    two_byte,
  input  logic                    fifo_full,
  output logic [DATA_WIDTH-1:0]   tx_data,
  output logic                    tx_vld,
  output logic                    done
);

  tx_state_t               r_state;
  logic [2*DATA_WIDTH-1:0] r_result;
  logic                    r_two_byte;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state    <= TX_IDLE;
      r_result   <= '0;
      r_two_byte <= 1'b0;
      tx_data    <= '0;
      tx_vld     <= 1'b0;
      done       <= 1'b0;
    end else begin
      tx_vld <= 1'b0;
      done   <= 1'b0;
      case (r_state)
        TX_IDLE: begin
          if (start) begin
            r_result   <= result;
            r_two_byte <= two_byte;
            r_state    <= TX_LO;
          end
        end
        TX_LO: begin
          // tx_data only moves on a write, so it holds steady through a stall
          if (!fifo_full) begin
            tx_data <= r_result[DATA_WIDTH-1:0];
            tx_vld  <= 1'b1;
            if (r_two_byte) begin
              r_state <= TX_HI;
            end else begin
              done    <= 1'b1;
              r_state <= TX_IDLE;
            end
          end
        end
        TX_HI: begin
          if (!fifo_full) begin
            tx_data <= r_result[2*DATA_WIDTH-1:DATA_WIDTH];
            tx_vld  <= 1'b1;
            done    <= 1'b1;
            r_state <= TX_IDLE;
          end
        end
        default: r_state <= TX_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/uart_cmd_ctrl.sv
// ============================================================================
// uart_cmd_ctrl : decodes UART command frames into register-file / ALU
//                 control and schedules result bytes into the TX FIFO.
//                 UART_CMD_TIMEOUT_EN adds an inter-byte frame timeout.
// Revision      : 1.0
// ============================================================================
`default_nettype none

module uart_cmd_ctrl
  import uart_cmd_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 4,
  parameter int FUN_WIDTH      = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [DATA_WIDTH-1:0]   RX_P_DATA,
  input  logic                    RX_D_VLD,
  input  logic [DATA_WIDTH-1:0]   RF_RdData,
  input  logic                    RF_RdData_VLD,
  input  logic [2*DATA_WIDTH-1:0] ALU_OUT,
  input  logic                    ALU_OUT_VLD,
  input  logic                    FIFO_FULL,
  output logic [ADDR_WIDTH-1:0]   RF_Address,
  output logic                    RF_WrEn,
  output logic                    RF_RdEn,
  output logic [DATA_WIDTH-1:0]   RF_WrData,
  output logic [FUN_WIDTH-1:0]    ALU_FUN,
  output logic                    ALU_EN,
  output logic                    CLK_GATE_EN,
  output logic [DATA_WIDTH-1:0]   TX_P_DATA,
  output logic                    TX_D_VLD,
  output logic                    CMD_ERR
);

  localparam logic [DATA_WIDTH-1:0] C_OPC_WR  = DATA_WIDTH'(OPC_RF_WR);
  localparam logic [DATA_WIDTH-1:0] C_OPC_RD  = DATA_WIDTH'(OPC_RF_RD);
  localparam logic [DATA_WIDTH-1:0] C_OPC_OP  = DATA_WIDTH'(OPC_ALU_OP);
  localparam logic [DATA_WIDTH-1:0] C_OPC_NOP = DATA_WIDTH'(OPC_ALU_NOP);
  localparam logic [ADDR_WIDTH-1:0] C_OPA     = ADDR_WIDTH'(OPA_ADDR);
  localparam logic [ADDR_WIDTH-1:0] C_OPB     = ADDR_WIDTH'(OPB_ADDR);

  generate
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be at least 1");
    end
  endgenerate

  cmd_state_t              r_state;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [2*DATA_WIDTH-1:0] r_result;
  logic                    r_two_byte;
  logic                    r_tx_start;
  logic                    r_alu_done;
  logic                    w_tx_done;
  logic                    w_timeout;

`ifdef UART_CMD_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] C_TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] r_cnt;
  logic          w_counting;

  assign w_counting = r_state inside {ST_WR_ADDR, ST_WR_DATA, ST_RD_ADDR,
                                      ST_OPA, ST_OPB, ST_FUN};
  assign w_timeout  = w_counting && !RX_D_VLD && (r_cnt == C_TO_LAST);

  always_ff @(posedge CLK) begin
    if (RST || RX_D_VLD || !w_counting) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state     <= ST_IDLE;
      r_addr      <= '0;
      r_result    <= '0;
      r_two_byte  <= 1'b0;
      r_tx_start  <= 1'b0;
      r_alu_done  <= 1'b0;
      RF_Address  <= '0;
      RF_WrEn     <= 1'b0;
      RF_RdEn     <= 1'b0;
      RF_WrData   <= '0;
      ALU_FUN     <= '0;
      ALU_EN      <= 1'b0;
      CLK_GATE_EN <= 1'b0;
      CMD_ERR     <= 1'b0;
    end else begin
      RF_WrEn    <= 1'b0;
      RF_RdEn    <= 1'b0;
      ALU_EN     <= 1'b0;
      CMD_ERR    <= 1'b0;
      r_tx_start <= 1'b0;
      if (ALU_OUT_VLD) CLK_GATE_EN <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          if (RX_D_VLD) begin
            case (RX_P_DATA)
              C_OPC_WR: r_state <= ST_WR_ADDR;
              C_OPC_RD: r_state <= ST_RD_ADDR;
              C_OPC_OP: r_state <= ST_OPA;
              C_OPC_NOP: begin
                r_state     <= ST_FUN;
                CLK_GATE_EN <= 1'b1;
                r_alu_done  <= 1'b0;
              end
              default: CMD_ERR <= 1'b1;
            endcase
          end
        end
        ST_WR_ADDR: begin
          if (RX_D_VLD) begin
            r_addr  <= RX_P_DATA[ADDR_WIDTH-1:0];
            r_state <= ST_WR_DATA;
          end
        end
        ST_WR_DATA: begin
          if (RX_D_VLD) begin
            RF_WrEn    <= 1'b1;
            RF_Address <= r_addr;
            RF_WrData  <= RX_P_DATA;
            r_state    <= ST_IDLE;
          end
        end
        ST_RD_ADDR: begin
          if (RX_D_VLD) begin
            RF_RdEn    <= 1'b1;
            RF_Address <= RX_P_DATA[ADDR_WIDTH-1:0];
            r_state    <= ST_RD_WAIT;
          end
        end
        ST_RD_WAIT: begin
          if (RF_RdData_VLD) begin
            r_result   <= {{DATA_WIDTH{1'b0}}, RF_RdData};
            r_two_byte <= 1'b0;
            r_tx_start <= 1'b1;
            r_state    <= ST_TX;
          end
        end
        ST_OPA: begin
          if (RX_D_VLD) begin
            RF_WrEn    <= 1'b1;
            RF_Address <= C_OPA;
            RF_WrData  <= RX_P_DATA;
            r_state    <= ST_OPB;
          end
        end
        ST_OPB: begin
          if (RX_D_VLD) begin
            RF_WrEn     <= 1'b1;
            RF_Address  <= C_OPB;
            RF_WrData   <= RX_P_DATA;
            CLK_GATE_EN <= 1'b1;
            r_alu_done  <= 1'b0;
            r_state     <= ST_FUN;
          end
        end
        ST_FUN: begin
          // an early result is remembered so ALU_WAIT can leave immediately
          if (ALU_OUT_VLD) begin
            r_result   <= ALU_OUT;
            r_alu_done <= 1'b1;
          end
          if (RX_D_VLD) begin
            ALU_FUN <= RX_P_DATA[FUN_WIDTH-1:0];
            ALU_EN  <= 1'b1;
            r_state <= ST_ALU_WAIT;
          end
        end
        ST_ALU_WAIT: begin
          if (ALU_OUT_VLD || r_alu_done) begin
            if (ALU_OUT_VLD) r_result <= ALU_OUT;
            r_alu_done <= 1'b0;
            r_two_byte <= 1'b1;
            r_tx_start <= 1'b1;
            r_state    <= ST_TX;
          end
        end
        ST_TX: begin
          if (w_tx_done) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase

      if (w_timeout) begin
        r_state     <= ST_IDLE;
        CMD_ERR     <= 1'b1;
        CLK_GATE_EN <= 1'b0;
        r_alu_done  <= 1'b0;
      end
    end
  end

  uart_cmd_tx_sched #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_tx_sched (
    .CLK       (CLK),
    .RST       (RST),
    .start     (r_tx_start),
    .result    (r_result),
    .two_byte  (r_two_byte),
    .fifo_full (FIFO_FULL),
    .tx_data   (TX_P_DATA),
    .tx_vld    (TX_D_VLD),
    .done      (w_tx_done)
  );

endmodule

`default_nettype wire

// File: doc/uart_cmd_ctrl.md
Name: uart_cmd_ctrl

Overview:
- Command sequencer between the UART receive path and the register-file/ALU/transmit datapath.
- Consumes validated RX bytes (byte plus one-cycle valid strobe; the strobe is withheld for frames with start, parity or stop errors).
- Decodes multi-byte command frames, drives register-file and ALU control, and schedules result bytes into the TX FIFO.
- Sits in the reference clock domain behind the RX data synchronizer.

Parameters:
- DATA_WIDTH, 8: RX/TX byte and register-file data width.
- ADDR_WIDTH, 4: register-file address width; taken from the low bits of the address byte.
- FUN_WIDTH, 4: ALU function code width; taken from the low bits of the function byte.
- TIMEOUT_CYCLES, 1024: inter-byte timeout; used only with the optional feature.

Ports:
- CLK, in, 1: reference clock.
- RST, in, 1: synchronous active-high reset.
- RX_P_DATA, in, DATA_WIDTH: received byte.
- RX_D_VLD, in, 1: one-cycle strobe; RX_P_DATA is valid this cycle.
- RF_RdData, in, DATA_WIDTH: register-file read data.
- RF_RdData_VLD, in, 1: read data valid.
- ALU_OUT, in, 2*DATA_WIDTH: ALU result.
- ALU_OUT_VLD, in, 1: ALU result valid.
- FIFO_FULL, in, 1: TX FIFO cannot accept a write.
- RF_Address, out, ADDR_WIDTH: register-file address.
- RF_WrEn, out, 1: register-file write strobe.
- RF_RdEn, out, 1: register-file read strobe.
- RF_WrData, out, DATA_WIDTH: register-file write data.
- ALU_FUN, out, FUN_WIDTH: ALU function select.
- ALU_EN, out, 1: ALU start strobe.
- CLK_GATE_EN, out, 1: ALU clock-gate enable.
- TX_P_DATA, out, DATA_WIDTH: byte to TX FIFO.
- TX_D_VLD, out, 1: TX FIFO write strobe.
- CMD_ERR, out, 1: one-cycle strobe on unknown opcode.

Behaviour:
- Reset: all outputs 0. State IDLE. Internal registers (address, function, result) 0. RST wins over any simultaneous input.
- Opcodes (first byte in IDLE):
  - 0xAA register write: next bytes are addr, then data.
  - 0xBB register read: next byte is addr.
  - 0xCC ALU with operands: next bytes are opA, opB, fun.
  - 0xDD ALU without operands: next byte is fun.
  - Any other byte: CMD_ERR pulses 1 cycle; state stays IDLE.
- State transitions (each byte-consuming state advances only on RX_D_VLD):
  - WR_ADDR -> WR_DATA.
  - WR_DATA -> IDLE. In the cycle after the strobe: RF_WrEn=1 for exactly 1 cycle, RF_Address = latched addr, RF_WrData = byte.
  - RD_ADDR -> RD_WAIT. RF_RdEn=1 for 1 cycle, one cycle after the strobe.
  - RD_WAIT: hold until RF_RdData_VLD; latch the data; -> TX_LO.
  - OPA: write the byte to RF address 0 (RF_WrEn pulse). -> OPB.
  - OPB: write the byte to RF address 1 (RF_WrEn pulse). -> FUN.
  - FUN: latch ALU_FUN. ALU_EN=1 for 1 cycle. CLK_GATE_EN=1 from FUN entry until ALU_OUT_VLD. -> ALU_WAIT.
  - ALU_WAIT: hold until ALU_OUT_VLD; latch the 16-bit result; -> TX_LO.
  - TX_LO: when !FIFO_FULL, TX_P_DATA = result[7:0], TX_D_VLD=1 for 1 cycle. Register reads go -> IDLE; ALU commands go -> TX_HI.
  - TX_HI: same rule with result[15:8]; -> IDLE.
- FIFO_FULL: stall in the TX state with TX_D_VLD=0 and TX_P_DATA stable. No byte is dropped or duplicated.
- RX_D_VLD outside byte-consuming states (RD_WAIT, ALU_WAIT, TX_*): ignored. The controller does not buffer it.
- Simultaneous events:
  - RX_D_VLD in the same cycle as the last TX write: ignored; the state reaches IDLE next cycle.
  - ALU_OUT_VLD arriving in FUN (a 1-cycle ALU): accepted; ALU_WAIT exits on its first cycle.
- Latency: RF write 1 cycle after the data strobe. TX first byte ≥1 cycle after the valid input.
- Width rules:
  - RF_Address = byte[ADDR_WIDTH-1:0]; upper bits are discarded with no error.
  - ALU_FUN = byte[FUN_WIDTH-1:0].
  - 0xDD reuses the existing RF[0]/RF[1] operands.

Optional Feature:
- Macro: UART_CMD_TIMEOUT_EN.
- Defined: a counter clears on every RX_D_VLD and counts cycles in WR_ADDR, WR_DATA, RD_ADDR, OPA, OPB and FUN. When it reaches TIMEOUT_CYCLES-1:
  - state -> IDLE, CMD_ERR pulses 1 cycle;
  - no RF or ALU strobe is issued;
  - a partial frame's already-written operands remain in RF.
- Undefined: no counter; the controller waits indefinitely in byte-consuming states.

Decomposition:
- Shared package uart_cmd_pkg:
  - opcode constants OPC_RF_WR=8'hAA, OPC_RF_RD=8'hBB, OPC_ALU_OP=8'hCC, OPC_ALU_NOP=8'hDD;
  - state enumeration;
  - RF operand addresses OPA_ADDR=0, OPB_ADDR=1.
- One sub-module: uart_cmd_tx_sched, holding the TX_LO/TX_HI byte sequencer with FIFO_FULL backpressure. Inputs: a 16-bit result, a two-byte flag and a start strobe. Output: a done strobe.

Test Plan:
- AA,05,3C strobed 4 cycles apart -> one RF_WrEn pulse with RF_Address=5, RF_WrData=0x3C; no TX_D_VLD.
- BB,07; RF_RdData=0x9E with VLD 2 cycles after RF_RdEn -> one TX_D_VLD with TX_P_DATA=0x9E; state IDLE afterwards.
- CC,03,04,00 with ALU_OUT=0x000C valid 1 cycle after ALU_EN -> RF[0]=3, RF[1]=4 writes, ALU_FUN=0, then TX bytes 0x0C then 0x00. CLK_GATE_EN drops after ALU_OUT_VLD.
- DD,02 with FIFO_FULL held high 5 cycles at TX_LO -> no TX_D_VLD during the stall, then 2 writes in LSB-then-MSB order, no duplicates.
- Byte 0x55 in IDLE -> CMD_ERR 1 cycle, no RF/ALU/TX activity. Then RST mid-frame (after AA,05) -> all outputs 0, and a subsequent 0x3C is treated as an opcode and raises CMD_ERR.
- With UART_CMD_TIMEOUT_EN, TIMEOUT_CYCLES=16: AA then silence -> CMD_ERR on cycle 16 after the strobe, state IDLE, RF_WrEn never asserted.
